// File: rtl/cell_sum_scheduler_pkg.sv
// Shared definitions for the cell force-summation scheduler.
// Holds the FSM state encoding, the header address and the default sizing.
// Also provides the index-width helper used by the arbiter and counters.
package cell_sum_scheduler_pkg;

    localparam int DEF_NUM_TOTAL_CELL  = 125;
    localparam int DEF_CELL_ID_WIDTH   = 7;
    localparam int DEF_ADDR_WIDTH      = 8;
    localparam int DEF_MAX_OUTSTANDING = 4;

    // Address 0 of every cell's force cache holds that cell's particle count
    localparam int HEADER_ADDR = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_HDR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Bits needed to index n items (never less than 1)
    function automatic int cell_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cell_sum_scheduler_if.sv
// Bundle between the scheduler, the cell-done scoreboard, the force caches and the adder.
// master = scheduler side, slave = environment side (scoreboard, caches, adder).
// Pure wiring: no latency and no storage of its own.
interface cell_sum_scheduler_if #(
    parameter int NUM_TOTAL_CELL = cell_sum_scheduler_pkg::DEF_NUM_TOTAL_CELL,
    parameter int CELL_ID_WIDTH  = cell_sum_scheduler_pkg::DEF_CELL_ID_WIDTH,
    parameter int ADDR_WIDTH     = cell_sum_scheduler_pkg::DEF_ADDR_WIDTH
);
    logic                      iter_start;
    logic [NUM_TOTAL_CELL-1:0] cell_ready;
    logic                      sum_ready;
    logic                      rd_en;
    logic [CELL_ID_WIDTH-1:0]  rd_cell_id;
    logic [ADDR_WIDTH-1:0]     rd_addr;
    logic                      rd_data_valid;
    logic [ADDR_WIDTH-1:0]     rd_count;
    logic                      to_adder_valid;
    logic                      cell_sum_done;
    logic                      busy;
    logic                      all_done;

    modport master (
        input  iter_start, cell_ready, sum_ready, rd_data_valid, rd_count,
        output rd_en, rd_cell_id, rd_addr, to_adder_valid, cell_sum_done, busy, all_done
    );

    modport slave (
        output iter_start, cell_ready, sum_ready, rd_data_valid, rd_count,
        input  rd_en, rd_cell_id, rd_addr, to_adder_valid, cell_sum_done, busy, all_done
    );
endinterface

// File: rtl/cell_sum_scheduler_rr_arbiter.sv
// Round-robin arbiter: first requesting index at or after i_ptr, wrapping N-1 -> 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume the grant.
module cell_sum_scheduler_rr_arbiter
    import cell_sum_scheduler_pkg::*;
#(
    parameter int N = DEF_NUM_TOTAL_CELL,
    parameter int W = DEF_CELL_ID_WIDTH
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_grant,
    output logic         o_grant_vld
);
    localparam int IW = cell_idx_width(2 * N);

    logic [2*N-1:0] w_req_dbl;
    logic [2*N-1:0] w_masked;
    logic [IW-1:0]  w_idx;
    logic           w_found;

    assign w_req_dbl = {i_req, i_req};

    // Drop requests below the pointer in the lower copy; the upper copy supplies the wrap-around
    always_comb begin
        for (int i = 0; i < 2 * N; i++) begin
            w_masked[i] = w_req_dbl[i] && (i >= int'(i_ptr));
        end
    end

    // Lowest set bit of the masked doubled vector is the winner
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!w_found && w_masked[i]) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
            end
        end
    end

    assign o_grant     = (int'(w_idx) >= N) ? W'(int'(w_idx) - N) : W'(w_idx);
    assign o_grant_vld = |i_req;

endmodule

// File: rtl/cell_sum_scheduler.sv
// Picks done cells round-robin and streams their force-cache reads (header, then particles) to the adder.
// Latency: header read 2 cycles after a cell becomes pending while idle; 2 cycles from DONE to next header.
// Backpressure: reads issue only with sum_ready=1 and fewer than MAX_OUTSTANDING reads in flight.
module cell_sum_scheduler
    import cell_sum_scheduler_pkg::*;
#(
    parameter int NUM_TOTAL_CELL  = DEF_NUM_TOTAL_CELL,
    parameter int CELL_ID_WIDTH   = DEF_CELL_ID_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING
) (
    input  logic                 clk,
    input  logic                 rst,
    cell_sum_scheduler_if.master bus
);
    localparam int OW = cell_idx_width(MAX_OUTSTANDING + 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [NUM_TOTAL_CELL-1:0] r_pending;
    logic [NUM_TOTAL_CELL-1:0] r_served;
    logic [NUM_TOTAL_CELL-1:0] w_pend_clr;
    logic [CELL_ID_WIDTH-1:0]  r_rr_ptr;
    logic [CELL_ID_WIDTH-1:0]  r_rd_cell_id;
    logic [CELL_ID_WIDTH-1:0]  w_grant;
    logic                      w_grant_vld;
    logic [ADDR_WIDTH-1:0]     r_rd_addr;
    logic [ADDR_WIDTH-1:0]     r_cnt;
    logic [OW-1:0]             r_outstanding;
    logic                      r_hdr_issued;
    logic                      w_rd_en;
    logic                      w_ret;
    logic                      w_can_issue;
    logic                      w_last_issue;

    cell_sum_scheduler_rr_arbiter #(
        .N (NUM_TOTAL_CELL),
        .W (CELL_ID_WIDTH)
    ) u_arb (
        .i_req       (r_pending),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_vld (w_grant_vld)
    );

    // A return with nothing in flight is stale (e.g. issued before a reset) and is dropped
    assign w_ret        = bus.rd_data_valid && (r_outstanding != '0);
    // A return in the same cycle frees a slot, so L == MAX_OUTSTANDING still streams back-to-back
    assign w_can_issue  = (r_outstanding < OW'(MAX_OUTSTANDING)) || w_ret;
    assign w_last_issue = (r_rd_addr == r_cnt);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state, read strobe and pending-clear decode
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        w_pend_clr  = '0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) w_state_nxt = ST_ARB;
            end
            ST_ARB: begin
                if (w_grant_vld) begin
                    w_pend_clr[w_grant] = 1'b1;
                    w_state_nxt         = ST_HDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                w_rd_en = !r_hdr_issued && bus.sum_ready;
                if (r_hdr_issued && w_ret) begin
                    w_state_nxt = (bus.rd_count == '0) ? ST_DONE : ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_rd_en = bus.sum_ready && w_can_issue;
                if (w_rd_en && w_last_issue) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_outstanding == '0) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_state_nxt = (|r_pending) ? ST_ARB : ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-cell read context: granted cell, read address, particle count, round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_cell_id <= '0;
            r_rd_addr    <= '0;
            r_cnt        <= '0;
            r_rr_ptr     <= '0;
            r_hdr_issued <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_grant_vld) begin
                        r_rd_cell_id <= w_grant;
                        r_rd_addr    <= ADDR_WIDTH'(HEADER_ADDR);
                        r_hdr_issued <= 1'b0;
                        r_rr_ptr     <= (int'(w_grant) == NUM_TOTAL_CELL - 1) ?
                                        '0 : w_grant + CELL_ID_WIDTH'(1);
                    end
                end
                ST_HDR: begin
                    if (w_rd_en) r_hdr_issued <= 1'b1;
                    if (r_hdr_issued && w_ret) begin
                        r_cnt <= bus.rd_count;
                        if (bus.rd_count != '0) r_rd_addr <= ADDR_WIDTH'(1);
                    end
                end
                ST_STREAM: begin
                    // Address stays on the last particle once it has been issued
                    if (w_rd_en && !w_last_issue) r_rd_addr <= r_rd_addr + ADDR_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    // Reads in flight: +1 per issue, -1 per accepted return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else begin
            case ({w_rd_en, w_ret})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: ;
            endcase
        end
    end

    // Pending set by cell_ready (wins over the grant clear); served set on done, cleared by iter_start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_served  <= '0;
        end else begin
            r_pending <= (r_pending & ~w_pend_clr) | bus.cell_ready;
            if (bus.iter_start)          r_served <= '0;
            else if (r_state == ST_DONE) r_served[r_rd_cell_id] <= 1'b1;
        end
    end

    assign bus.rd_en          = w_rd_en;
    assign bus.rd_cell_id     = r_rd_cell_id;
    assign bus.rd_addr        = r_rd_addr;
    assign bus.to_adder_valid = w_ret && ((r_state == ST_STREAM) || (r_state == ST_DRAIN));
    assign bus.cell_sum_done  = (r_state == ST_DONE);
    assign bus.busy           = (r_state != ST_IDLE);
    assign bus.all_done       = &r_served;

endmodule

// File: doc/cell_sum_scheduler.md
Name: cell_sum_scheduler

Overview:
- Schedules force summation per cell: a round-robin pick over cells whose short-range evaluation is done, then sequences force-cache reads for each particle of the granted cell.
- Sits between the cell-done scoreboard and the force caches/summation adder.
- Replaces the ready-buffer-plus-access-FSM pair with one arbitrated, flow-controlled controller.

Parameters:
- NUM_TOTAL_CELL, 125, number of cells (5x5x5).
- CELL_ID_WIDTH, 7, width of a cell index; at least clog2(NUM_TOTAL_CELL).
- ADDR_WIDTH, 8, per-cell force-cache address width. Address 0 holds the particle count.
- MAX_OUTSTANDING, 4, maximum cache reads in flight.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- iter_start  in  1  1-cycle pulse; clears the served mask for a new timestep
- cell_ready  in  NUM_TOTAL_CELL  1-cycle pulse per bit: cell's short-range forces are complete
- sum_ready  in  1  downstream adder can accept data; gates read issue
- rd_en  out  1  cache read strobe
- rd_cell_id  out  CELL_ID_WIDTH  cell being read
- rd_addr  out  ADDR_WIDTH  address within the cell
- rd_data_valid  in  1  cache return strobe (in order, fixed latency of 1 cycle or more)
- rd_count  in  ADDR_WIDTH  particle count field; sampled only on the header return
- to_adder_valid  out  1  qualifies the current return as particle force data (header excluded)
- cell_sum_done  out  1  1-cycle pulse: all particles of rd_cell_id returned
- busy  out  1  state is not IDLE
- all_done  out  1  served mask is all-ones

Behaviour:
- Reset (async): all outputs 0, state IDLE, pending=0, served=0, outstanding=0, rr_ptr=0.
- Pending register:
  - pending[i] is set by cell_ready[i] and cleared when cell i is granted.
  - If set and clear hit the same cycle, set wins, so the cell is served again.
- Served register:
  - served[i] is set on cell i's cell_sum_done.
  - iter_start clears served; if iter_start and cell_sum_done coincide, iter_start wins.
- Arbiter: round-robin. Choose the first pending index at or after rr_ptr, wrapping from NUM_TOTAL_CELL-1 to 0. On grant, rr_ptr = grant+1, with wrap.
- IDLE: if pending != 0, go to ARB the next cycle.
- ARB: latch the grant into rd_cell_id, clear its pending bit, go to HDR.
- HDR:
  - Issue rd_en with rd_addr=0 in the first cycle sum_ready=1.
  - Wait for rd_data_valid, then latch rd_count into cnt.
  - If cnt==0, go to DONE; otherwise set rd_addr=1 and go to STREAM.
- STREAM:
  - Issue a read when sum_ready=1 and outstanding<MAX_OUTSTANDING; rd_addr then increments.
  - After issuing address cnt, go to DRAIN.
- DRAIN: wait until outstanding==0, then go to DONE.
- DONE: pulse cell_sum_done for 1 cycle. Go to ARB if pending != 0, else IDLE.
- Outstanding counter:
  - +1 per rd_en, -1 per rd_data_valid; both in one cycle leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING.
  - A return with outstanding==0 is ignored (assertion in bench).
- to_adder_valid = rd_data_valid while in STREAM or DRAIN (the header return is excluded).
- Throughput: with sum_ready held at 1 and latency L <= MAX_OUTSTANDING, one read per cycle.
- Cell-to-cell gap: exactly 2 cycles between the DONE cycle and the next header read (DONE, ARB).
- rd_cell_id and rd_addr are held stable while rd_en=0.
- Reset mid-operation aborts immediately: all state is cleared, and in-flight returns after reset are ignored.

Decomposition:
- Shared package: state encoding (IDLE, ARB, HDR, STREAM, DRAIN, DONE), HEADER_ADDR=0, and the cell-index width function.
- One sub-module, rr_arbiter, parameterised on N: inputs req vector and ptr; outputs grant index and grant_valid. Combinational priority logic using a doubled-vector mask.

Test Plan:
- Single cell, L=2, sum_ready=1: cell_ready[7] pulse with count=3 → header read, reads at addr 1,2,3 on consecutive cycles, 3 to_adder_valid pulses, one cell_sum_done with rd_cell_id=7, served[7]=1.
- Zero-count cell: cell_ready[0] with count=0 → one header read, then cell_sum_done; no to_adder_valid.
- Fairness and wrap: rr_ptr=124; cell_ready[3], [124] and [0] pulsed together → grant order 124, 0, 3.
- Backpressure: count=8, L=6, sum_ready toggled 1010 → outstanding never exceeds 4; all 8 returns arrive; addresses issued strictly 1..8.
- Set-wins race: cell_ready[5] re-pulses in the ARB cycle that grants cell 5 → cell 5 is served twice; after iter_start and all 125 cells served, all_done=1.
- Async reset during STREAM (3 of 8 reads issued): assert rst mid-cycle → outputs 0 immediately. After release, a new cell_ready[2] is processed normally; stale returns are ignored.
